mode_select_fsm: RTL and testbench
==================================

Name: mode_select_fsm

Overview:
- Parametrised top-level game/mode selector for the benchmark console.
- Debounces one-hot-per-mode key requests from the PS/2 decode layer, waits for key release, then enters the chosen game mode with a one-cycle start pulse.
- Returns to the menu on a back request.
- Feeds the display mux and each game's start logic.
- Supports any number of modes; mode 0 is always the menu.

Parameters:
- NUM_MODES, 2: number of selectable game modes (keys); minimum 1.
- DEBOUNCE_CYCLES, 4: consecutive cycles a key must be sampled high to qualify; minimum 1.
- IDLE_CYCLES, 1000000: idle timeout length in cycles; used only with IDLE_TIMEOUT_EN.
- MODE_W (localparam): $clog2(NUM_MODES+1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- iResetn  in  1  asynchronous active-low reset.
- iKey  in  NUM_MODES  level per mode key; bit k requests mode k+1.
- iBack  in  1  level, return-to-menu request (formerly the soft reset key).
- oMode  out  MODE_W  registered; 0 = menu, k+1 = game k active.
- oStart  out  1  one-cycle pulse on entry to a game mode.
- oActive  out  1  high while in ACTIVE.
- oTimeout  out  1  one-cycle pulse on idle exit; constant 0 without the macro.

Behaviour:
- States: MENU, SEL_WAIT, ACTIVE, EXIT_WAIT. All outputs are registered.
- Reset (iResetn low, async):
  - state = MENU; oMode = 0; oStart = 0; oActive = 0; oTimeout = 0.
  - Debounce counter = 0; sel = 0; idle counter = 0.
  - Reset mid-operation aborts immediately; no oStart or oTimeout is generated.
- Candidate key = lowest-index asserted bit of iKey. Simultaneous keys resolve to the lowest index.
- MENU:
  - iBack high: go to EXIT_WAIT, clear the debounce counter. Back wins over any key in the same cycle.
  - Else, candidate present and equal to the previous cycle's candidate: increment the debounce counter.
  - Else, candidate present but different from the previous candidate: counter = 1.
  - Else (no candidate): counter = 0.
  - On the edge where the counter would reach DEBOUNCE_CYCLES: latch sel = candidate index, go to SEL_WAIT.
  - Timing: a key first sampled high at edge 1 and held causes the transition at edge DEBOUNCE_CYCLES.
  - The counter saturates; it never wraps.
- SEL_WAIT:
  - oMode stays 0.
  - iBack high: go to EXIT_WAIT (selection discarded, no oStart).
  - Else, iKey == 0 (all keys released): go to ACTIVE. On that same edge oMode = sel+1, oActive = 1, oStart = 1.
  - Else: stay.
- ACTIVE:
  - oStart drops to 0 the next cycle. Keys are ignored for mode selection (game use).
  - iBack high: go to EXIT_WAIT. On that edge oMode = 0, oActive = 0.
- EXIT_WAIT:
  - oMode = 0.
  - iBack low: go to MENU with the debounce counter cleared.
  - A key held across the exit does not count toward debounce until sampled in MENU.
- Unreachable state encodings recover to MENU on the next edge with oMode = 0.

Optional Feature:
- Macro: IDLE_TIMEOUT_EN.
- With the macro defined:
  - In ACTIVE, an idle counter increments each cycle while iKey == 0 and iBack == 0.
  - Any asserted iKey bit clears the counter.
  - When the counter reaches IDLE_CYCLES-1 with no activity: go directly to MENU on that edge. oMode = 0, oActive = 0, oTimeout = 1 for one cycle.
  - The counter clears on every ACTIVE entry.
  - If iBack is high in the same cycle, iBack takes precedence (EXIT_WAIT, no oTimeout).
- Without the macro: no idle counter is built, oTimeout is tied 0, and ACTIVE exits only via iBack or reset.

Test Plan:
- Reset: hold iResetn low 3 cycles with iKey = 2'b11 -> oMode = 0, oStart = 0, oActive = 0 throughout; release -> FSM in MENU.
- Select (NUM_MODES=2, DEBOUNCE_CYCLES=4): iKey = 2'b10 for 6 cycles, then 0 -> SEL_WAIT after edge 4; oMode = 2 and oStart = 1 on the first edge sampling iKey = 0; oStart = 0 the next cycle.
- Glitch: iKey = 2'b01 for 3 cycles, 0 for 1, then 3 more cycles -> no selection, oMode remains 0; a 4th continuous cycle selects.
- Priority: iKey = 2'b11 held 4 cycles then released -> oMode = 1. Repeat with iBack = 1 in the same cycles -> EXIT_WAIT, oMode = 0, no oStart.
- Exit: in ACTIVE mode 2, pulse iBack 5 cycles -> oMode = 0 on the first iBack edge; MENU entered on the first edge with iBack = 0. Async iResetn low mid-ACTIVE -> outputs 0 immediately, no clock needed.
- Timeout (IDLE_TIMEOUT_EN, IDLE_CYCLES=8): enter mode 1, no input -> oTimeout = 1 for one cycle at the 8th idle edge, oMode = 0. A key pulse at idle cycle 5 restarts the count.

Source files
------------

// File: rtl/mode_select_fsm.sv
// Game/mode selector: debounces per-mode key requests, waits for release, enters the mode with a start pulse.
// Optional idle timeout back to the menu is built only when IDLE_TIMEOUT_EN is defined.
module mode_select_fsm #(
  parameter int NUM_MODES       = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int IDLE_CYCLES     = 1000000
) (
  input  logic                             clk,
  input  logic                             iResetn,
  input  logic [NUM_MODES-1:0]             iKey,
  input  logic                             iBack,
  output logic [$clog2(NUM_MODES+1)-1:0]   oMode,
  output logic                             oStart,
  output logic                             oActive,
  output logic                             oTimeout
);

  localparam int MODE_W = $clog2(NUM_MODES + 1);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  localparam logic [1:0] MENU      = 2'd0;
  localparam logic [1:0] SEL_WAIT  = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;
  localparam logic [1:0] EXIT_WAIT = 2'd3;

  if (NUM_MODES < 1) begin : g_chk_modes
    $error("mode_select_fsm: NUM_MODES must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("mode_select_fsm: DEBOUNCE_CYCLES must be at least 1");
  end
  if (IDLE_CYCLES < 1) begin : g_chk_idle
    $error("mode_select_fsm: IDLE_CYCLES must be at least 1");
  end

  logic [1:0]        state;
  logic [CNT_W-1:0]  deb_cnt;
  logic [CNT_W-1:0]  deb_next;
  logic [MODE_W-1:0] sel;
  logic [MODE_W-1:0] prev_cand;
  logic [MODE_W-1:0] cand_idx;
  logic              cand_vld;

  // Lowest-index key wins when several are pressed together.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    for (int k = NUM_MODES - 1; k >= 0; k--) begin
      if (iKey[k]) begin
        cand_vld = 1'b1;
        cand_idx = MODE_W'(k);
      end
    end
  end

  // A zero counter makes "same candidate" and "new candidate" both yield 1.
  always_comb begin
    deb_next = '0;
    if (cand_vld) begin
      if (cand_idx != prev_cand)
        deb_next = CNT_W'(1);
      else if (deb_cnt == DEB_MAX)
        deb_next = deb_cnt;
      else
        deb_next = deb_cnt + CNT_W'(1);
    end
  end

`ifdef IDLE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_now;

  assign idle_now = (iKey == '0) && !iBack;
`else
  assign oTimeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state     <= MENU;
      deb_cnt   <= '0;
      sel       <= '0;
      prev_cand <= '0;
      oMode     <= '0;
      oStart    <= 1'b0;
      oActive   <= 1'b0;
`ifdef IDLE_TIMEOUT_EN
      idle_cnt  <= '0;
      oTimeout  <= 1'b0;
`endif
    end else begin
      oStart   <= 1'b0;
`ifdef IDLE_TIMEOUT_EN
      oTimeout <= 1'b0;
`endif
      case (state)
        MENU: begin
          oMode   <= '0;
          oActive <= 1'b0;
          prev_cand <= cand_idx;
          if (iBack) begin
            state   <= EXIT_WAIT;
            deb_cnt <= '0;
          end else if (cand_vld && (deb_next == DEB_MAX)) begin
            state   <= SEL_WAIT;
            sel     <= cand_idx;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_next;
          end
        end
        SEL_WAIT: begin
          if (iBack) begin
            state <= EXIT_WAIT;
          end else if (iKey == '0) begin
            state   <= ACTIVE;
            oMode   <= sel + MODE_W'(1);
            oActive <= 1'b1;
            oStart  <= 1'b1;
`ifdef IDLE_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        ACTIVE: begin
          if (iBack) begin
            state   <= EXIT_WAIT;
            oMode   <= '0;
            oActive <= 1'b0;
`ifdef IDLE_TIMEOUT_EN
          end else if (!idle_now) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= MENU;
            oMode    <= '0;
            oActive  <= 1'b0;
            oTimeout <= 1'b1;
            deb_cnt  <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
`endif
          end
        end
        EXIT_WAIT: begin
          oMode   <= '0;
          oActive <= 1'b0;
          deb_cnt <= '0;
          if (!iBack)
            state <= MENU;
        end
        default: begin
          state   <= MENU;
          oMode   <= '0;
          oActive <= 1'b0;
          deb_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_select_fsm.sv
// Directed self-checking bench for mode_select_fsm (NUM_MODES=2, DEBOUNCE_CYCLES=4, IDLE_CYCLES=8).
// Timeout steps are compiled in only when IDLE_TIMEOUT_EN is defined.
module tb_mode_select_fsm;

  logic       clk;
  logic       iResetn;
  logic [1:0] iKey;
  logic       iBack;
  logic [1:0] oMode;
  logic       oStart;
  logic       oActive;
  logic       oTimeout;

  int vectors;
  int miscompares;

  mode_select_fsm #(
    .NUM_MODES      (2),
    .DEBOUNCE_CYCLES(4),
    .IDLE_CYCLES    (8)
  ) dut (
    .clk     (clk),
    .iResetn (iResetn),
    .iKey    (iKey),
    .iBack   (iBack),
    .oMode   (oMode),
    .oStart  (oStart),
    .oActive (oActive),
    .oTimeout(oTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] mode, input logic start,
                     input logic active, input logic tout);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {oMode, oStart, oActive, oTimeout};
    exp = {mode, start, active, tout};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed mode/start/active/timeout=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Debounce for 4 edges, release, and expect the start pulse.
  task automatic enter_mode(input logic [1:0] key, input logic [1:0] mode, input string tag);
    iKey = key;
    repeat (4) tick();
    chk({tag, "_selwait"}, 2'd0, 1'b0, 1'b0, 1'b0);
    iKey = 2'b00;
    tick();
    chk({tag, "_start"}, mode, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic back_to_menu(input string tag);
    iBack = 1'b1;
    tick();
    chk({tag, "_back"}, 2'd0, 1'b0, 1'b0, 1'b0);
    iBack = 1'b0;
    tick();
    chk({tag, "_menu"}, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    iResetn     = 1'b0;
    iKey        = 2'b11;
    iBack       = 1'b0;

    // Reset held with keys pressed
    #1;
    chk("reset_async", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", 2'd0, 1'b0, 1'b0, 1'b0);
    end
    iKey    = 2'b00;
    iResetn = 1'b1;
    tick();
    chk("reset_release", 2'd0, 1'b0, 1'b0, 1'b0);

    // Select mode 2: key held 6 cycles then released
    iKey = 2'b10;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sel_hold", 2'd0, 1'b0, 1'b0, 1'b0);
    end
    iKey = 2'b00;
    tick();
    chk("sel_start", 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("sel_start_drop", 2'd2, 1'b0, 1'b1, 1'b0);
    iKey = 2'b01;
    tick();
    chk("active_ignores_key", 2'd2, 1'b0, 1'b1, 1'b0);
    iKey = 2'b00;

    // Exit: back for 5 cycles, key held across the last two and the release
    iBack = 1'b1;
    tick();
    chk("exit_first_edge", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) iKey = 2'b01;
      tick();
      chk("exit_hold", 2'd0, 1'b0, 1'b0, 1'b0);
    end
    iBack = 1'b0;
    tick();
    chk("exit_to_menu", 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    iKey = 2'b00;
    tick();
    chk("exit_key_not_counted", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("exit_key_not_counted2", 2'd0, 1'b0, 1'b0, 1'b0);

    // Glitch: 3 high, 1 low, 3 high -> nothing; 4th continuous selects
    iKey = 2'b01;
    repeat (3) tick();
    iKey = 2'b00;
    tick();
    iKey = 2'b01;
    repeat (3) tick();
    iKey = 2'b00;
    tick();
    chk("glitch_no_sel", 2'd0, 1'b0, 1'b0, 1'b0);
    iKey = 2'b01;
    repeat (3) tick();
    chk("glitch_3_of_4", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    iKey = 2'b00;
    tick();
    chk("glitch_4th_selects", 2'd1, 1'b1, 1'b1, 1'b0);
    back_to_menu("glitch");

    // Priority: both keys -> lowest index
    enter_mode(2'b11, 2'd1, "prio");
    back_to_menu("prio");

    // Back in the same cycles as both keys wins
    iKey  = 2'b11;
    iBack = 1'b1;
    repeat (4) tick();
    chk("prio_back_hold", 2'd0, 1'b0, 1'b0, 1'b0);
    iKey  = 2'b00;
    iBack = 1'b0;
    tick();
    chk("prio_back_release", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("prio_back_no_start", 2'd0, 1'b0, 1'b0, 1'b0);

    // Back during SEL_WAIT discards the selection
    iKey = 2'b10;
    repeat (4) tick();
    iBack = 1'b1;
    tick();
    iKey  = 2'b00;
    iBack = 1'b0;
    tick();
    chk("selwait_back_release", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("selwait_back_no_start", 2'd0, 1'b0, 1'b0, 1'b0);

`ifdef IDLE_TIMEOUT_EN
    // Timeout at the 8th idle edge
    enter_mode(2'b01, 2'd1, "tmo");
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("tmo_idle", 2'd1, 1'b0, 1'b1, 1'b0);
    end
    tick();
    chk("tmo_fire", 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("tmo_pulse_drop", 2'd0, 1'b0, 1'b0, 1'b0);

    // Key pulse at idle cycle 5 restarts the count
    enter_mode(2'b01, 2'd1, "tmo2");
    repeat (4) tick();
    iKey = 2'b10;
    tick();
    iKey = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("tmo2_restart_idle", 2'd1, 1'b0, 1'b1, 1'b0);
    end
    tick();
    chk("tmo2_fire", 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
`else
    // No idle exit without the timeout feature
    enter_mode(2'b01, 2'd1, "noidle");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noidle_stay", 2'd1, 1'b0, 1'b1, 1'b0);
    end
    back_to_menu("noidle");
`endif

    // Async reset mid-ACTIVE clears outputs without a clock edge
    enter_mode(2'b10, 2'd2, "arst");
    tick();
    @(negedge clk);
    iResetn = 1'b0;
    #1;
    chk("arst_immediate", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("arst_hold", 2'd0, 1'b0, 1'b0, 1'b0);
    iResetn = 1'b1;
    tick();
    chk("arst_release", 2'd0, 1'b0, 1'b0, 1'b0);
    enter_mode(2'b10, 2'd2, "arst_reenter");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
